// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; guarded so a degenerate width still yields a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used by the serial adder datapath.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic c2
);
  assign sum = a ^ b ^ c;
  assign c2  = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, carry held in a flop between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_s, fa_c;

  fa u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .c   (carry_q),
    .sum (fa_s),
    .c2  (fa_c)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        // Hold the counter on the last bit so it never wraps.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_sr_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance plus a 2-bit instance for the exhaustive sweep.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum;

  logic       in_valid2 = 1'b0, out_ready2 = 1'b1, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, cout2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle on the 8-bit instance; returns at the negedge after the accept edge.
  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges since accept until out_valid shows; lat = 0 at the first negedge after accept.
  task automatic wait_done8(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [7:0] es, input logic ec);
    int lat;
    start8(av, bv, cv);
    wait_done8(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] hs;
    logic       hc;
    logic [2:0] exp2;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("cin", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    op8("plain", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Backpressure: result and flags must hold while out_ready is low.
    out_ready = 1'b0;
    start8(8'h80, 8'h80, 1'b1);
    wait_done8(lat);
    chk("bp_lat", 32'(lat), 32'd8);
    hs = sum; hc = cout;
    chk("bp_sum", 32'(sum), 32'h01);
    chk("bp_cout", 32'(cout), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_sum", 32'(sum), 32'(hs));
      chk("bp_hold_cout", 32'(cout), 32'(hc));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    chk("bp_release_vld", 32'(out_valid), 32'd0);

    // Busy-input rejection: a second pair offered mid-shift must be dropped.
    start8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 8'h00; b = 8'h00;
    lat = 2;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_lat", 32'(lat), 32'd8);
    chk("busy_sum", 32'(sum), 32'h30);
    chk("busy_cout", 32'(cout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("busy_no_replay", 32'(out_valid), 32'd0);
    end
    chk("busy_idle", 32'(in_ready), 32'd1);

    // Reset at cnt=3: three edges after the first SHIFT cycle begins.
    start8(8'hF0, 8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    op8("post_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // Exhaustive 2-bit sweep, back-to-back.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      @(negedge clk);
      chk("w2_ready", 32'(in_ready2), 32'd1);
      a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      exp2 = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
      chk("w2_lat", 32'(lat), 32'd2);
      chk("w2_result", 32'({cout2, sum2}), 32'(exp2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them LSB-first, one bit per clock. Each bit passes through a single `fa` full-adder cell, with the carry held in a flip-flop between cycles. It is the sequential stage directly downstream of the `fa` cell. It trades latency for area compared with a WIDTH-wide ripple adder, and returns the sum and carry-out over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands a/b/cin are valid this cycle.
- in_ready, output, 1, block can accept operands (IDLE only).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- out_valid, output, 1, sum/cout are valid and held.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, a + b + cin modulo 2^WIDTH.
- cout, output, 1, carry out of bit WIDTH-1.

## Operation
- Three-state FSM: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, go to SHIFT.
- **SHIFT**
  - in_ready=0.
  - Each cycle, `fa` computes s,c from (a_sr[0], b_sr[0], carry).
  - sum_sr<={s, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1, the same edge captures the final bit and transitions to DONE.
- **DONE**
  - out_valid=1, sum=sum_sr, cout=carry; all held stable while out_ready=0.
  - On out_ready: go to IDLE. sum/cout keep their last value; out_valid drops.
- in_valid outside IDLE is ignored; operands are not buffered.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true bit WIDTH.
- cnt width is $clog2(WIDTH); it never wraps because exit occurs at WIDTH-1.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
  - carry, cnt and shift registers are 0.
- Reset during SHIFT or DONE aborts the operation; no result is ever presented for it.
- Latency: operands accepted at edge k (in_valid & in_ready) give out_valid=1 after edge k+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH in SHIFT, ≥1 in DONE, 1 in IDLE.
- in_ready is combinational from state only, with no dependence on in_valid.
- out_valid is registered from state, with no dependence on out_ready.
- out_valid & out_ready at edge m gives in_ready=1 after edge m. New operands are accepted no earlier than edge m+1.
- No combinational path from any input to any output.

## Structure
- Package `serial_adder_pkg`:
  - state typedef (IDLE, SHIFT, DONE, 2-bit encoding).
  - localparam default WIDTH=8.
  - function computing the cnt width.
- Sub-module: one instance of the existing `fa` cell, ports (a, b, c, sum, c2), driven by a_sr[0], b_sr[0], carry.
- Everything else lives in `serial_adder`: FSM, counter, three shift registers, carry flop.

## Test plan
- **Basic carry ripple.** WIDTH=8, a=0xFF, b=0x01, cin=0, out_ready=1.
  - Expect sum=0x00, cout=1.
  - out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle.
- **Carry-in propagation.** a=0xA5, b=0x5A, cin=1.
  - Expect sum=0x00, cout=1.
  - Then a=0x12, b=0x34, cin=0: expect sum=0x46, cout=0.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid.
  - sum/cout/out_valid stay stable and in_ready stays 0.
  - After out_ready=1 for one cycle, in_ready=1 on the next cycle.
- **Busy-input rejection.** Pulse in_valid with a=0x01, b=0x01 during SHIFT of a=0x10, b=0x20.
  - Result is 0x30, cout=0; the second operand pair is never consumed.
- **Reset mid-operation.** Assert rst_n=0 at cnt=3.
  - Outputs go immediately to in_ready=1, out_valid=0, sum=0, cout=0.
  - A fresh a=0x0F, b=0x01 then yields 0x10.
- **Exhaustive check.** WIDTH=2, all 32 (a, b, cin) combinations back-to-back.
  - Each {cout, sum} equals a+b+cin.
